vend_sequencer: RTL and testbench

- Synchronous credit-and-dispense controller for the farthing/ha'penny/penny vending machine.
- Accepts single-cycle coin events from the debounced, edge-detected coin path and accumulates credit in farthings.
- When credit reaches the price, it requests a vend, then pays out change one coin at a time over req/ack handshakes to the ha'penny and farthing hoppers.
- Also handles cancel and refund, and traps hopper or vend timeouts in a sticky FAULT state.

---
 rtl/vend_sequencer.sv | 147 ++++++++++++++
 tb/tb_vend_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// Credit-and-dispense controller for the farthing/ha'penny/penny vending machine.
// Accumulates coin credit, requests a vend, then pays change one coin per handshake.
module vend_sequencer #(
   parameter int unsigned PRICE       = 4,
   parameter int unsigned CREDIT_MAX  = 15,
   parameter int unsigned ACK_TIMEOUT = 1023
) (
   input  logic       clk50m,
   input  logic       res,
   input  logic [2:0] coin,
   input  logic       cancel,
   input  logic       vend_ack,
   input  logic       hap_ack,
   input  logic       far_ack,
   output logic [3:0] credit,
   output logic       vend_req,
   output logic       hap_req,
   output logic       far_req,
   output logic       coin_reject,
   output logic       busy,
   output logic       fault,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StVend  = 3'd1,
      StChg   = 3'd2,
      StGap   = 3'd3,
      StFault = 3'd4
   } state_e;

   localparam int unsigned     CntW      = $clog2(ACK_TIMEOUT + 1);
   localparam logic [4:0]      CreditMax = 5'(CREDIT_MAX);
   localparam logic [3:0]      Price     = 4'(PRICE);
   localparam logic [CntW-1:0] CntLast   = CntW'(ACK_TIMEOUT - 1);

   state_e          state_q, state_d;
   logic [3:0]      credit_q, credit_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            coin_reject_q, coin_reject_d;

   logic [2:0] win_bit;
   logic [2:0] win_val;
   logic [4:0] credit_sum;
   logic       credited;
   logic       vend_req_c, hap_req_c, far_req_c, req_any, timeout;

   // Penny beats ha'penny beats farthing; losers are always returned.
   always_comb begin
      win_bit = 3'b000;
      win_val = 3'd0;
      if (coin[0]) begin
         win_bit = 3'b001;
         win_val = 3'd4;
      end else if (coin[1]) begin
         win_bit = 3'b010;
         win_val = 3'd2;
      end else if (coin[2]) begin
         win_bit = 3'b100;
         win_val = 3'd1;
      end
   end

   assign credit_sum = {1'b0, credit_q} + {2'b00, win_val};

   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      cnt_d      = cnt_q;
      credited   = 1'b0;
      vend_req_c = (state_q == StVend);
      hap_req_c  = (state_q == StChg) && (credit_q >= 4'd2);
      far_req_c  = (state_q == StChg) && (credit_q == 4'd1);
      req_any    = vend_req_c | hap_req_c | far_req_c;
      timeout    = req_any && (cnt_q == CntLast);

      case (state_q)
         StIdle: begin
            if (cancel && (credit_q != 4'd0)) begin
               state_d = StChg;
            end else if (credit_q >= Price) begin
               state_d = StVend;
            end else if ((win_bit != 3'b000) && (credit_sum <= CreditMax)) begin
               credit_d = credit_sum[3:0];
               credited = 1'b1;
            end
         end
         StVend: begin
            if (vend_ack) begin
               credit_d = credit_q - Price;
               state_d  = (credit_q == Price) ? StIdle : StChg;
            end else if (timeout) begin
               state_d = StFault;
            end
         end
         StChg: begin
            // An ack from the hopper that is not being asked is dropped.
            if (hap_req_c && hap_ack) begin
               credit_d = credit_q - 4'd2;
               state_d  = StGap;
            end else if (far_req_c && far_ack) begin
               credit_d = credit_q - 4'd1;
               state_d  = StGap;
            end else if (timeout) begin
               state_d = StFault;
            end
         end
         StGap:   state_d = (credit_q != 4'd0) ? StChg : StIdle;
         StFault: state_d = StFault;
         default: state_d = StIdle;
      endcase

      // Each VEND/CHG entry gets a fresh timeout window.
      if (((state_d == StVend) || (state_d == StChg)) && (state_d != state_q)) begin
         cnt_d = '0;
      end else if (req_any) begin
         cnt_d = cnt_q + 1'b1;
      end

      coin_reject_d = |(coin & ~(credited ? win_bit : 3'b000));
   end

   always_ff @(posedge clk50m) begin
      if (res) begin
         state_q       <= StIdle;
         credit_q      <= 4'd0;
         cnt_q         <= '0;
         coin_reject_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         cnt_q         <= cnt_d;
         coin_reject_q <= coin_reject_d;
      end
   end

   assign credit      = credit_q;
   assign vend_req    = vend_req_c;
   assign hap_req     = hap_req_c;
   assign far_req     = far_req_c;
   assign coin_reject = coin_reject_q;
   assign busy        = (state_q != StIdle);
   assign fault       = (state_q == StFault);
   assign state       = state_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboard bench for vend_sequencer: hand-derived expectations queued per stimulus cycle.
// Instance a uses PRICE=4/ACK_TIMEOUT=8, instance b uses PRICE=15 for the overflow case.
module tb_vend_sequencer;

   localparam logic [2:0] NC = 3'b000, P = 3'b001, H = 3'b010, F = 3'b100;
   localparam logic [2:0] NA = 3'b000, VA = 3'b100, HA = 3'b010, FA = 3'b001;
   localparam logic [2:0] R0 = 3'b000, RV = 3'b100, RH = 3'b010, RF = 3'b001;
   localparam logic [2:0] SI = 3'd0, SV = 3'd1, SC = 3'd2, SG = 3'd3, SF = 3'd4;

   logic clk = 1'b0;
   logic res = 1'b0;

   logic [2:0] a_coin = '0, b_coin = '0;
   logic a_cancel = 1'b0, a_vack = 1'b0, a_hack = 1'b0, a_fack = 1'b0;
   logic b_cancel = 1'b0, b_vack = 1'b0, b_hack = 1'b0, b_fack = 1'b0;
   logic [3:0] a_credit, b_credit;
   logic [2:0] a_state, b_state;
   logic a_vreq, a_hreq, a_freq, a_rej, a_busy, a_fault;
   logic b_vreq, b_hreq, b_freq, b_rej, b_busy, b_fault;

   vend_sequencer #(.PRICE(4), .CREDIT_MAX(15), .ACK_TIMEOUT(8)) dut_a (
      .clk50m(clk), .res(res), .coin(a_coin), .cancel(a_cancel),
      .vend_ack(a_vack), .hap_ack(a_hack), .far_ack(a_fack),
      .credit(a_credit), .vend_req(a_vreq), .hap_req(a_hreq), .far_req(a_freq),
      .coin_reject(a_rej), .busy(a_busy), .fault(a_fault), .state(a_state)
   );

   vend_sequencer #(.PRICE(15), .CREDIT_MAX(15), .ACK_TIMEOUT(1023)) dut_b (
      .clk50m(clk), .res(res), .coin(b_coin), .cancel(b_cancel),
      .vend_ack(b_vack), .hap_ack(b_hack), .far_ack(b_fack),
      .credit(b_credit), .vend_req(b_vreq), .hap_req(b_hreq), .far_req(b_freq),
      .coin_reject(b_rej), .busy(b_busy), .fault(b_fault), .state(b_state)
   );

   always #5 clk = ~clk;

   // {sel, state, credit, vend_req, hap_req, far_req, coin_reject, busy, fault}
   logic [13:0] exp_q[$];
   string       tag_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   logic        sel = 1'b0;
   string       scen = "init";
   int          idx = 0;

   task automatic check_eq(input string tag, input logic [12:0] obs, input logic [12:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got st=%0d cr=%0d vhf_rej_busy_fault=%b want st=%0d cr=%0d vhf_rej_busy_fault=%b",
                  tag, obs[12:10], obs[9:6], obs[5:0], exp[12:10], exp[9:6], exp[5:0]);
      end else begin
         n_pass++;
      end
   endtask

   always @(negedge clk) begin
      logic [13:0] e;
      string       t;
      logic [12:0] obs;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         if (e[13]) obs = {b_state, b_credit, b_vreq, b_hreq, b_freq, b_rej, b_busy, b_fault};
         else       obs = {a_state, a_credit, a_vreq, a_hreq, a_freq, a_rej, a_busy, a_fault};
         check_eq(t, obs, e[12:0]);
      end
   end

   task automatic push_exp(input logic [2:0] st, input logic [3:0] cr, input logic [2:0] req,
                           input logic rej);
      exp_q.push_back({sel, st, cr, req, rej, st != SI, st == SF});
      tag_q.push_back($sformatf("%s.%0d", scen, idx));
      idx++;
   endtask

   // Drive one cycle of inputs and queue the outputs expected after that edge.
   task automatic step(input logic [2:0] c, input logic can, input logic [2:0] ack,
                       input logic [2:0] st, input logic [3:0] cr, input logic [2:0] req,
                       input logic rej);
      if (!sel) begin
         a_coin = c; a_cancel = can; {a_vack, a_hack, a_fack} = ack;
      end else begin
         b_coin = c; b_cancel = can; {b_vack, b_hack, b_fack} = ack;
      end
      push_exp(st, cr, req, rej);
      @(posedge clk);
      #1;
      a_coin = '0; a_cancel = 1'b0; {a_vack, a_hack, a_fack} = '0;
      b_coin = '0; b_cancel = 1'b0; {b_vack, b_hack, b_fack} = '0;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      res = 1'b1;
      push_exp(SI, 4'd0, R0, 1'b0);
      @(posedge clk);
      #1;
      res = 1'b0;
      @(negedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      #1;
      scen = "reset"; idx = 0;
      do_reset();

      scen = "vend"; idx = 0;
      step(P,  0, NA, SI, 4'd4, R0, 0);
      step(NC, 0, NA, SV, 4'd4, RV, 0);
      step(NC, 0, VA, SI, 4'd0, R0, 0);
      step(NC, 0, NA, SI, 4'd0, R0, 0);

      scen = "change"; idx = 0;
      step(H,  0, NA, SI, 4'd2, R0, 0);
      step(F,  0, NA, SI, 4'd3, R0, 0);
      step(P,  0, NA, SI, 4'd7, R0, 0);
      step(NC, 0, NA, SV, 4'd7, RV, 0);
      step(NC, 0, NA, SV, 4'd7, RV, 0);
      step(NC, 0, VA, SC, 4'd3, RH, 0);
      step(NC, 0, FA, SC, 4'd3, RH, 0);
      step(NC, 0, HA, SG, 4'd1, R0, 0);
      step(NC, 0, NA, SC, 4'd1, RF, 0);
      step(NC, 0, FA, SG, 4'd0, R0, 0);
      step(NC, 0, NA, SI, 4'd0, R0, 0);

      scen = "multi"; idx = 0;
      step(3'b111, 0, NA, SI, 4'd4, R0, 1);
      step(F,      0, NA, SV, 4'd4, RV, 1);
      step(H,      0, NA, SV, 4'd4, RV, 1);
      step(NC,     1, NA, SV, 4'd4, RV, 0);
      step(NC,     0, VA, SI, 4'd0, R0, 0);

      scen = "cancel"; idx = 0;
      step(H,  0, NA, SI, 4'd2, R0, 0);
      step(F,  0, NA, SI, 4'd3, R0, 0);
      step(NC, 1, NA, SC, 4'd3, RH, 0);
      step(H,  1, HA, SG, 4'd1, R0, 1);
      step(NC, 0, NA, SC, 4'd1, RF, 0);
      step(NC, 0, FA, SG, 4'd0, R0, 0);
      step(NC, 0, NA, SI, 4'd0, R0, 0);
      step(NC, 1, NA, SI, 4'd0, R0, 0);
      step(NC, 0, NA, SI, 4'd0, R0, 0);
      step(F,  0, NA, SI, 4'd1, R0, 0);
      step(P,  1, NA, SC, 4'd1, RF, 1);
      step(NC, 0, FA, SG, 4'd0, R0, 0);
      step(NC, 0, NA, SI, 4'd0, R0, 0);

      scen = "timeout"; idx = 0;
      step(P,  0, NA, SI, 4'd4, R0, 0);
      step(NC, 0, NA, SV, 4'd4, RV, 0);
      for (int i = 0; i < 7; i++) step(NC, 0, NA, SV, 4'd4, RV, 0);
      step(NC, 0, NA, SF, 4'd4, R0, 0);
      step(H,  1, VA, SF, 4'd4, R0, 1);
      step(NC, 0, NA, SF, 4'd4, R0, 0);
      do_reset();
      step(NC, 0, NA, SI, 4'd0, R0, 0);

      scen = "ack_at_limit"; idx = 0;
      step(P,  0, NA, SI, 4'd4, R0, 0);
      step(NC, 0, NA, SV, 4'd4, RV, 0);
      for (int i = 0; i < 7; i++) step(NC, 0, NA, SV, 4'd4, RV, 0);
      step(NC, 0, VA, SI, 4'd0, R0, 0);

      scen = "reset_chg"; idx = 0;
      step(H,  0, NA, SI, 4'd2, R0, 0);
      step(F,  0, NA, SI, 4'd3, R0, 0);
      step(NC, 1, NA, SC, 4'd3, RH, 0);
      do_reset();
      step(NC, 0, NA, SI, 4'd0, R0, 0);

      sel = 1'b1;
      scen = "overflow"; idx = 0;
      do_reset();
      step(P,  0, NA, SI, 4'd4,  R0, 0);
      step(P,  0, NA, SI, 4'd8,  R0, 0);
      step(P,  0, NA, SI, 4'd12, R0, 0);
      step(P,  0, NA, SI, 4'd12, R0, 1);
      step(F,  0, NA, SI, 4'd13, R0, 0);
      step(H,  0, NA, SI, 4'd15, R0, 0);
      step(NC, 0, NA, SV, 4'd15, RV, 0);
      step(NC, 0, VA, SI, 4'd0,  R0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
